lector_destinos: RTL and testbench
==================================

LECTOR_DESTINOS -- requirements
Module: lector_destinos

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all other ports are synchronous to the clock.
REQ-002 Parameter BW, default 6, SHALL set the data word width.
REQ-003 Parameter CW, default 8, SHALL set the width of each receive counter.
REQ-004 Parameter DEST_BIT, default 4, SHALL set the data bit index that encodes the destination (0 = D0, 1 = D1).
REQ-005 Port clk, input, 1 bit, SHALL be the clock (rising edge).
REQ-006 Port reset, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-007 Port en, input, 1 bit, SHALL enable reading from the destination FIFOs.
REQ-008 Port empty_d0 / empty_d1, input, 1 bit each, SHALL be the registered empty flags of FIFO D0 / D1.
REQ-009 Port data_out0 / data_out1, input, BW each, SHALL be FIFO read data, valid in the cycle after the corresponding pop.
REQ-010 Port pop_D0 / pop_D1, output, 1 bit each, SHALL be the pop strobes to D0 / D1.
REQ-011 Port data_rx, output, BW, SHALL carry the received word.
REQ-012 Port valid_rx, output, 1 bit, SHALL mark data_rx valid for one cycle.
REQ-013 Port dest_rx, output, 1 bit, SHALL give the source FIFO of data_rx (0 = D0).
REQ-014 Port rx_count_d0 / rx_count_d1, output, CW each, SHALL count words received per FIFO.
REQ-015 Port err_count, output, 4 bits, SHALL count destination-mismatch words.
REQ-016 Port error_out, output, 1 bit, SHALL be a sticky mismatch flag.
REQ-017 Port idle_out, output, 1 bit, SHALL be high when no read is issued or in flight.

Function
REQ-018 The FSM SHALL have states IDLE and ACTIVE, encoded in registers.
REQ-019 IDLE SHALL move to ACTIVE when en=1 and (empty_d0=0 or empty_d1=0).
REQ-020 ACTIVE SHALL move to IDLE when en=0 or both empty flags are 1.
REQ-021 In ACTIVE, at most one pop SHALL be asserted per cycle, and never to a FIFO whose empty flag is 1.
REQ-022 Arbitration SHALL be round-robin: when both FIFOs are non-empty, alternate, starting with D0 after reset.
REQ-023 When only one FIFO is non-empty, it SHALL be popped every cycle.
REQ-024 Pops SHALL be combinational from the current state, empty flags and en (no registered pop delay).
REQ-025 Latency SHALL be fixed: pop in cycle t, data sampled in t+1, and data_rx/valid_rx/dest_rx registered and visible in t+2.
REQ-026 valid_rx SHALL be high for exactly one cycle per pop; back-to-back pops SHALL yield back-to-back valid words in pop order.
REQ-027 data_rx and dest_rx SHALL hold their last value when valid_rx=0.
REQ-028 rx_count_dX SHALL increment in the same cycle valid_rx is set for that source, and SHALL saturate at 2^CW-1 (no wrap).
REQ-029 A word SHALL be a mismatch when data[DEST_BIT] differs from its source FIFO index.
REQ-030 On a mismatch, err_count SHALL increment (saturating at 15) and error_out SHALL set and stay set until reset.
REQ-031 Mismatched words SHALL still be delivered on data_rx with valid_rx=1.
REQ-032 idle_out SHALL be 1 when the state is IDLE and no pop was issued in the last two cycles.
REQ-033 When en falls mid-stream, words already popped SHALL still be delivered, and no new pop SHALL issue from that cycle on.

Reset
REQ-034 Reset assertion SHALL asynchronously force: state IDLE, pop_D0=pop_D1=0, valid_rx=0, data_rx=0, dest_rx=0, all counters 0, error_out=0, idle_out=1, round-robin pointer to D0.
REQ-035 Words in flight at reset SHALL be discarded.
REQ-036 The first pop SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-037 D0 holds 0x01..0x05 (bit4=0), D1 empty, en=1 -> pop_D0 high 5 consecutive cycles; data_rx 0x01..0x05 with valid_rx on cycles t+2..t+6; rx_count_d0=5; error_out=0.
REQ-038 Both FIFOs hold 3 words each (D1 words 0x30..0x32) -> pops alternate D0, D1, D0, ...; dest_rx alternates 0,1; both counters reach 3.
REQ-039 D0 holds word 0x10 (bit4=1) -> valid_rx with data_rx=0x10; err_count=1; error_out=1 and held through 20 further idle cycles.
REQ-040 en dropped while D0 holds 10 words, after 4 pops -> exactly 4 words delivered; idle_out=1 two cycles after the last pop.
REQ-041 Reset asserted between a pop and its delivery -> valid_rx stays 0, all counters 0; the next pop occurs after reset deasserts.
REQ-042 With CW=3, D0 holds 10 words -> rx_count_d0 saturates at 7.

Source files
------------

// File: rtl/lector_destinos_if.sv
// Bus between the destination reader and its two destination FIFOs.
// master = reader side (issues pops, produces rx results); slave = FIFO/consumer side.
interface lector_destinos_if #(
  parameter int BW = 6,
  parameter int CW = 8
);
  logic          en;
  logic          empty_d0;
  logic          empty_d1;
  logic [BW-1:0] data_out0;
  logic [BW-1:0] data_out1;
  logic          pop_D0;
  logic          pop_D1;
  logic [BW-1:0] data_rx;
  logic          valid_rx;
  logic          dest_rx;
  logic [CW-1:0] rx_count_d0;
  logic [CW-1:0] rx_count_d1;
  logic [3:0]    err_count;
  logic          error_out;
  logic          idle_out;

  modport master (
    input  en, empty_d0, empty_d1, data_out0, data_out1,
    output pop_D0, pop_D1, data_rx, valid_rx, dest_rx,
           rx_count_d0, rx_count_d1, err_count, error_out, idle_out
  );

  modport slave (
    output en, empty_d0, empty_d1, data_out0, data_out1,
    input  pop_D0, pop_D1, data_rx, valid_rx, dest_rx,
           rx_count_d0, rx_count_d1, err_count, error_out, idle_out
  );
endinterface

// File: rtl/lector_destinos.sv
// Round-robin reader for two destination FIFOs: pops, delivers words two cycles
// later, counts words per source and flags words whose destination bit disagrees.
module lector_destinos #(
  parameter int BW       = 6,
  parameter int CW       = 8,
  parameter int DEST_BIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  lector_destinos_if.master  bus
);
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_q;
  logic          rr_q;          // 0: D0 wins the next tie, 1: D1 wins
  logic          p1_valid_q;
  logic          p1_src_q;
  logic [BW-1:0] data_rx_q;
  logic          valid_rx_q;
  logic          dest_rx_q;
  logic [CW-1:0] cnt0_q;
  logic [CW-1:0] cnt1_q;
  logic [3:0]    err_q;
  logic          error_q;
  logic          idle_q;

  logic          go_active;
  logic          pop0;
  logic          pop1;
  logic [BW-1:0] sel_data;
  logic          mismatch;

  assign go_active = bus.en && (!bus.empty_d0 || !bus.empty_d1);

  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (state_q == ACTIVE && bus.en) begin
      if (!bus.empty_d0 && !bus.empty_d1) begin
        pop0 = !rr_q;
        pop1 = rr_q;
      end else begin
        pop0 = !bus.empty_d0;
        pop1 = !bus.empty_d1;
      end
    end
  end

  // FIFO read data arrives one cycle after the pop; the source is remembered alongside
  assign sel_data = p1_src_q ? bus.data_out1 : bus.data_out0;
  assign mismatch = (sel_data[DEST_BIT] != p1_src_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_src_q   <= 1'b0;
      data_rx_q  <= '0;
      valid_rx_q <= 1'b0;
      dest_rx_q  <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= '0;
      error_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (go_active)  state_q <= ACTIVE;
        ACTIVE:  if (!go_active) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (pop0)      rr_q <= 1'b1;
      else if (pop1) rr_q <= 1'b0;

      p1_valid_q <= pop0 || pop1;
      if (pop0 || pop1) p1_src_q <= pop1;

      valid_rx_q <= p1_valid_q;
      if (p1_valid_q) begin
        data_rx_q <= sel_data;
        dest_rx_q <= p1_src_q;
        if (!p1_src_q && cnt0_q != {CW{1'b1}}) cnt0_q <= cnt0_q + CW'(1);
        if (p1_src_q && cnt1_q != {CW{1'b1}})  cnt1_q <= cnt1_q + CW'(1);
        if (mismatch) begin
          error_q <= 1'b1;
          if (err_q != 4'hF) err_q <= err_q + 4'd1;
        end
      end

      // Idle next cycle only if the FSM lands in IDLE and nothing was popped now
      idle_q <= !go_active && !(pop0 || pop1);
    end
  end

  assign bus.pop_D0      = pop0;
  assign bus.pop_D1      = pop1;
  assign bus.data_rx     = data_rx_q;
  assign bus.valid_rx    = valid_rx_q;
  assign bus.dest_rx     = dest_rx_q;
  assign bus.rx_count_d0 = cnt0_q;
  assign bus.rx_count_d1 = cnt1_q;
  assign bus.err_count   = err_q;
  assign bus.error_out   = error_q;
  assign bus.idle_out    = idle_q;
endmodule

// File: tb/tb_lector_destinos.sv
// Bench for lector_destinos: bench-side FIFO models, a transaction-level reference
// model (expected delivery queue, plain counters) and directed plus random traffic.
module tb_lector_destinos;
  localparam int BW = 6;
  localparam int CW = 8;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lector_destinos_if #(.BW(BW), .CW(CW)) bus ();
  lector_destinos_if #(.BW(BW), .CW(3))  bus3 ();

  lector_destinos #(.BW(BW), .CW(CW), .DEST_BIT(DB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  lector_destinos #(.BW(BW), .CW(3), .DEST_BIT(DB)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  assign bus3.en        = bus.en;
  assign bus3.empty_d0  = bus.empty_d0;
  assign bus3.empty_d1  = bus.empty_d1;
  assign bus3.data_out0 = bus.data_out0;
  assign bus3.data_out1 = bus.data_out1;

  typedef struct {
    int            due;
    logic          src;
    logic [BW-1:0] data;
  } wrd_t;

  wrd_t          exp_q[$];
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];

  int            n_pass = 0;
  int            n_checks = 0;
  int            cyc = 0;
  int            last_pop = -100;
  int            tot0 = 0;
  int            tot1 = 0;
  int            err_m = 0;
  int            delivered = 0;
  int            n_pops = 0;
  logic          act_m = 1'b0;
  logic          rr_m = 1'b0;
  logic          errf_m = 1'b0;
  logic [BW-1:0] last_data = '0;
  logic          last_dest = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock cycle: check outputs mid low phase, advance the model, then let the FIFOs respond.
  task automatic step();
    logic ep0, ep1, exp_v;
    wrd_t w;
    #1;
    ep0 = 1'b0;
    ep1 = 1'b0;
    if (act_m && bus.en && !reset) begin
      if (!bus.empty_d0 && !bus.empty_d1) begin
        if (rr_m) ep1 = 1'b1; else ep0 = 1'b1;
      end else if (!bus.empty_d0) ep0 = 1'b1;
      else if (!bus.empty_d1)     ep1 = 1'b1;
    end
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (exp_v) begin
      w = exp_q.pop_front();
      last_data = w.data;
      last_dest = w.src;
      if (w.src) tot1++; else tot0++;
      if (w.data[DB] != w.src) begin
        err_m  = sat(err_m + 1, 15);
        errf_m = 1'b1;
      end
      delivered++;
      $display("cycle %0d: rx src=D%0d data=%02h", cyc, w.src, w.data);
    end
    chk("pop_D0", bus.pop_D0, ep0);
    chk("pop_D1", bus.pop_D1, ep1);
    chk("valid_rx", bus.valid_rx, exp_v);
    chk("data_rx", bus.data_rx, last_data);
    chk("dest_rx", bus.dest_rx, last_dest);
    chk("rx_count_d0", bus.rx_count_d0, sat(tot0, 255));
    chk("rx_count_d1", bus.rx_count_d1, sat(tot1, 255));
    chk("err_count", bus.err_count, err_m);
    chk("error_out", bus.error_out, errf_m);
    chk("idle_out", bus.idle_out, !act_m && (cyc - last_pop >= 2));
    chk("cw3_pop_D0", bus3.pop_D0, ep0);
    chk("cw3_valid_rx", bus3.valid_rx, exp_v);
    chk("cw3_rx_count_d0", bus3.rx_count_d0, sat(tot0, 7));
    chk("cw3_rx_count_d1", bus3.rx_count_d1, sat(tot1, 7));

    if (ep0) begin
      exp_q.push_back('{cyc + 2, 1'b0, q0[0]});
      rr_m = 1'b1;
      last_pop = cyc;
      n_pops++;
    end
    if (ep1) begin
      exp_q.push_back('{cyc + 2, 1'b1, q1[0]});
      rr_m = 1'b0;
      last_pop = cyc;
      n_pops++;
    end
    act_m = !reset && bus.en && (!bus.empty_d0 || !bus.empty_d1);
    cyc++;

    @(posedge clk);
    #1;
    if (ep0) bus.data_out0 = q0.pop_front();
    if (ep1) bus.data_out1 = q1.pop_front();
    bus.empty_d0 = (q0.size() == 0);
    bus.empty_d1 = (q1.size() == 0);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    act_m = 1'b0;
    rr_m = 1'b0;
    last_pop = -100;
    tot0 = 0;
    tot1 = 0;
    err_m = 0;
    errf_m = 1'b0;
    last_data = '0;
    last_dest = 1'b0;
    run(n);
    reset = 1'b0;
  endtask

  initial begin
    int d0_before;
    int got;
    bus.en = 1'b0;
    bus.empty_d0 = 1'b1;
    bus.empty_d1 = 1'b1;
    bus.data_out0 = '0;
    bus.data_out1 = '0;
    @(negedge clk);
    do_reset(2);
    run(2);

    // Single busy FIFO: five back-to-back pops and deliveries
    for (int i = 1; i <= 5; i++) q0.push_back(BW'(i));
    bus.en = 1'b1;
    run(10);
    chk("req37_cnt0", bus.rx_count_d0, 5);
    chk("req37_error", bus.error_out, 0);

    // Both FIFOs busy: alternation starting with D0
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      q0.push_back(BW'(8'h0A + i));
      q1.push_back(BW'(8'h30 + i));
    end
    run(12);
    chk("req38_cnt0", bus.rx_count_d0, 3);
    chk("req38_cnt1", bus.rx_count_d1, 3);

    // Mismatched destination bit on D0
    q0.push_back(BW'(8'h10));
    run(5);
    chk("req39_err", bus.err_count, 1);
    run(20);
    chk("req39_sticky", bus.error_out, 1);

    // en dropped after four pops
    do_reset(1);
    for (int i = 0; i < 10; i++) q0.push_back(BW'(i));
    d0_before = n_pops;
    for (int i = 0; i < 40 && n_pops - d0_before < 4; i++) step();
    chk("req40_pops", n_pops - d0_before, 4);
    bus.en = 1'b0;
    d0_before = delivered;
    run(6);
    got = delivered - d0_before;
    chk("req40_delivered", got, 2);
    chk("req40_total", bus.rx_count_d0, 4);
    chk("req40_idle", bus.idle_out, 1);
    bus.en = 1'b1;
    run(12);

    // Reset between a pop and its delivery
    do_reset(1);
    q0.push_back(BW'(8'h05));
    q0.push_back(BW'(8'h06));
    d0_before = n_pops;
    for (int i = 0; i < 20 && n_pops == d0_before; i++) step();
    chk("req41_popped", n_pops - d0_before, 1);
    do_reset(2);
    run(6);
    chk("req41_cnt0", bus.rx_count_d0, 1);

    // Narrow counter saturation
    do_reset(1);
    for (int i = 0; i < 10; i++) q0.push_back(BW'(i));
    run(15);
    chk("req42_sat7", bus3.rx_count_d0, 7);
    chk("req42_cnt10", bus.rx_count_d0, 10);

    // Random traffic, long enough to saturate the wide counters and err_count
    do_reset(1);
    for (int i = 0; i < 1300; i++) begin
      if ($urandom_range(0, 3) != 0 && q0.size() < 8) q0.push_back(BW'($urandom));
      if ($urandom_range(0, 3) != 0 && q1.size() < 8) q1.push_back(BW'($urandom));
      bus.en = ($urandom_range(0, 9) != 0);
      step();
    end
    bus.en = 1'b1;
    run(40);
    chk("rand_drained", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
